cci_rd_arbiter: RTL and testbench

- Shares the single CCI-P c0 read-request channel among N_REQ independent read engines inside pipearch_top.
- Round-robin arbitration; per-requester outstanding-credit limit; honours c0TxAlmFull; tags each request via mdata; steers read responses back to the owning requester.
- Quiesce handshake lets the scheduler drain all in-flight reads before reconfiguring the engines.

---
 rtl/pipearch_arb_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/cci_rd_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cci_rd_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipearch_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipearch_arb_pkg : shared types for the CCI-P channel arbiters             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package pipearch_arb_pkg;

  typedef logic [7:0] t_req_id;
  typedef logic [7:0] t_seq;

  typedef struct packed {
    t_seq    seq;
    t_req_id id;
  } t_mdata;

  localparam int MDATA_ID_LSB  = 0;
  localparam int MDATA_SEQ_LSB = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2
  } t_qstate;

  function automatic t_mdata make_mdata(input t_seq seq, input t_req_id id);
    t_mdata m;
    m.seq = seq;
    m.id  = id;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : one-hot round-robin grant, pointer moves past the winner      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] eligible_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int IW    = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin : grant_search
    logic [IW-1:0] idx;
    logic          found;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = {1'b0, ptr_q} + IW'(off);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!found && eligible_i[idx[PTR_W-1:0]]) begin
        grant_o[idx[PTR_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (advance_i && grant_o[i]) ptr_d = (i == N - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/cci_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cci_rd_arbiter : shares the CCI-P c0 read channel among N_REQ engines      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cci_rd_arbiter
  import pipearch_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [7:0]              rsp_seq,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    c0_tx_valid,
  output logic [ADDR_W-1:0]       c0_tx_addr,
  output logic [15:0]             c0_tx_mdata,
  input  logic                    c0_tx_almfull,
  input  logic                    c0_rx_valid,
  input  logic [15:0]             c0_rx_mdata,
  input  logic [DATA_W-1:0]       c0_rx_data,
  input  logic                    quiesce_req,
  output logic                    quiesce_ack,
  output logic [15:0]             outstanding_total,
  output logic                    err_sticky
);

  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  t_qstate          state_q, state_d;
  logic             run_en;
  logic             grant_en;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             accept;

  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  t_seq             seq_q [N_REQ];
  logic [15:0]      total_q, total_d;

  logic [ADDR_W-1:0] sel_addr;
  t_mdata            sel_mdata;
  logic              tx_valid_q;
  logic [ADDR_W-1:0] tx_addr_q;
  t_mdata            tx_mdata_q;

  t_req_id           rx_id;
  t_seq              rx_seq;
  logic [N_REQ-1:0]  rsp_hit;
  logic              rsp_ok;
  logic [N_REQ-1:0]  rsp_valid_q;
  t_seq              rsp_seq_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              err_q;

  // reset_n gates the grant so req_ready is low while reset is held
  assign grant_en = run_en && !c0_tx_almfull && reset_n;
  assign rx_id    = c0_rx_mdata[MDATA_ID_LSB +: 8];
  assign rx_seq   = c0_rx_mdata[MDATA_SEQ_LSB +: 8];

  always_comb begin
    eligible = '0;
    rsp_hit  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && grant_en;
      rsp_hit[i]  = c0_rx_valid && (rx_id == t_req_id'(i)) && (cnt_q[i] != '0);
    end
  end

  assign rsp_ok = |rsp_hit;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .eligible_i (eligible),
    .advance_i  (accept),
    .grant_o    (grant)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  always_comb begin
    sel_addr  = '0;
    sel_mdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_mdata = make_mdata(seq_q[i], t_req_id'(i));
      end
    end
  end

  // An accept and a response for the same requester cancel out
  always_comb begin
    total_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({grant[i], rsp_hit[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      total_d = total_d + 16'(cnt_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
        seq_q[i] <= '0;
      end
      total_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (grant[i]) seq_q[i] <= seq_q[i] + 8'd1;
      end
      total_q <= total_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid_q <= 1'b0;
      tx_addr_q  <= '0;
      tx_mdata_q <= '0;
    end else begin
      tx_valid_q <= accept;
      if (accept) begin
        tx_addr_q  <= sel_addr;
        tx_mdata_q <= sel_mdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_seq_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_hit;
      if (rsp_ok) begin
        rsp_seq_q  <= rx_seq;
        rsp_data_q <= c0_rx_data;
      end
      if (c0_rx_valid && !rsp_ok) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (quiesce_req) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce_req)                          state_d = RUN;
        else if (total_q == '0 && !tx_valid_q)     state_d = QUIESCED;
      end
      QUIESCED: if (!quiesce_req) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Grants stop in the very cycle quiesce_req rises
  always_comb begin
    run_en      = (state_q == RUN) && !quiesce_req;
    quiesce_ack = (state_q == QUIESCED);
  end

  assign c0_tx_valid       = tx_valid_q;
  assign c0_tx_addr        = tx_addr_q;
  assign c0_tx_mdata       = tx_mdata_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_seq           = rsp_seq_q;
  assign rsp_data          = rsp_data_q;
  assign outstanding_total = total_q;
  assign err_sticky        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cci_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cci_rd_arbiter : directed self-checking bench for cci_rd_arbiter        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cci_rd_arbiter;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 42;
  localparam int DATA_W  = 512;
  localparam int MAX_OUT = 4;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [7:0]              rsp_seq;
  logic [DATA_W-1:0]       rsp_data;
  logic                    c0_tx_valid;
  logic [ADDR_W-1:0]       c0_tx_addr;
  logic [15:0]             c0_tx_mdata;
  logic                    c0_tx_almfull;
  logic                    c0_rx_valid;
  logic [15:0]             c0_rx_mdata;
  logic [DATA_W-1:0]       c0_rx_data;
  logic                    quiesce_req;
  logic                    quiesce_ack;
  logic [15:0]             outstanding_total;
  logic                    err_sticky;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] pat;

  always #5 clk = ~clk;

  cci_rd_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_seq           (rsp_seq),
    .rsp_data          (rsp_data),
    .c0_tx_valid       (c0_tx_valid),
    .c0_tx_addr        (c0_tx_addr),
    .c0_tx_mdata       (c0_tx_mdata),
    .c0_tx_almfull     (c0_tx_almfull),
    .c0_rx_valid       (c0_rx_valid),
    .c0_rx_mdata       (c0_rx_mdata),
    .c0_rx_data        (c0_rx_data),
    .quiesce_req       (quiesce_req),
    .quiesce_ack       (quiesce_ack),
    .outstanding_total (outstanding_total),
    .err_sticky        (err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    req_valid     = '0;
    req_addr      = '0;
    c0_tx_almfull = 1'b0;
    c0_rx_valid   = 1'b0;
    c0_rx_mdata   = '0;
    c0_rx_data    = '0;
    quiesce_req   = 1'b0;
    pat           = {16{32'hA5A5_5A5A}};
    for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h100 + i);

    // reset values
    #3;
    chk("rst_ready",  64'(req_ready), 64'(0));
    chk("rst_txv",    64'(c0_tx_valid), 64'(0));
    chk("rst_rspv",   64'(rsp_valid), 64'(0));
    chk("rst_ack",    64'(quiesce_ack), 64'(0));
    chk("rst_total",  64'(outstanding_total), 64'(0));
    chk("rst_err",    64'(err_sticky), 64'(0));
    tick; tick;
    reset_n = 1'b1;
    tick;

    // round robin over two laps
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
      tick;
      chk("rr_txv",   64'(c0_tx_valid), 64'(1));
      chk("rr_mdata", 64'(c0_tx_mdata), 64'({8'(k / 4), 8'(k % 4)}));
      chk("rr_addr",  64'(c0_tx_addr), 64'(32'h100 + k % 4));
    end
    req_valid = '0;
    chk("rr_total", 64'(outstanding_total), 64'(8));
    tick;
    chk("rr_idle_txv", 64'(c0_tx_valid), 64'(0));

    // steer responses back
    for (int k = 0; k < 8; k++) begin
      c0_rx_valid = 1'b1;
      c0_rx_mdata = {8'(k / 4), 8'(k % 4)};
      c0_rx_data  = pat ^ DATA_W'(k);
      tick;
      chk("rsp_onehot", 64'(rsp_valid), 64'(1 << (k % 4)));
      chk("rsp_seq",    64'(rsp_seq), 64'(k / 4));
    end
    c0_rx_valid = 1'b0;
    tick;
    chk("rsp_idle",   64'(rsp_valid), 64'(0));
    chk("rsp_total0", 64'(outstanding_total), 64'(0));
    chk("rsp_err0",   64'(err_sticky), 64'(0));

    // credit limit on requester 2
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cred_ready", 64'(req_ready), 64'(4'b0100));
      tick;
    end
    #1 chk("cred_block", 64'(req_ready), 64'(0));
    chk("cred_total4", 64'(outstanding_total), 64'(4));
    tick; tick;
    chk("cred_block_hold", 64'(req_ready), 64'(0));
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0002;
    tick;
    chk("cred_rsp",      64'(rsp_valid), 64'(4'b0100));
    chk("cred_total3",   64'(outstanding_total), 64'(3));
    chk("cred_reopen",   64'(req_ready), 64'(4'b0100));
    tick;
    chk("cred_same_cyc", 64'(outstanding_total), 64'(3));
    chk("cred_same_txv", 64'(c0_tx_valid), 64'(1));
    c0_rx_valid = 1'b0;
    tick;
    chk("cred_total4b",  64'(outstanding_total), 64'(4));
    chk("cred_block2",   64'(req_ready), 64'(0));
    req_valid   = '0;
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0002;
    repeat (4) tick;
    c0_rx_valid = 1'b0;
    tick;
    chk("cred_drained", 64'(outstanding_total), 64'(0));

    // almfull blocks grants
    c0_tx_almfull = 1'b1;
    req_valid     = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1 chk("af_ready", 64'(req_ready), 64'(0));
      tick;
      chk("af_txv", 64'(c0_tx_valid), 64'(0));
    end
    c0_tx_almfull = 1'b0;
    #1 chk("af_release", 64'(req_ready), 64'(4'b1000));
    tick;
    c0_tx_almfull = 1'b1;
    chk("af_late_txv",   64'(c0_tx_valid), 64'(1));
    chk("af_late_mdata", 64'(c0_tx_mdata), 64'(16'h0203));
    chk("af_late_addr",  64'(c0_tx_addr), 64'(32'h103));
    #1 chk("af_late_ready", 64'(req_ready), 64'(0));
    tick;
    chk("af_after_txv", 64'(c0_tx_valid), 64'(0));
    c0_tx_almfull = 1'b0;
    req_valid     = '0;

    // response steering and bad tag
    req_valid = 4'b0010;
    #1 chk("r1_ready", 64'(req_ready), 64'(4'b0010));
    tick;
    req_valid = '0;
    chk("r1_mdata", 64'(c0_tx_mdata), 64'(16'h0201));
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0501;
    c0_rx_data  = pat;
    tick;
    c0_rx_valid = 1'b0;
    chk("r1_rspv", 64'(rsp_valid), 64'(4'b0010));
    chk("r1_seq",  64'(rsp_seq), 64'(5));
    checks++;
    assert (rsp_data === pat) else begin
      failures++;
      $error("FAIL r1_data observed=%0h expected=%0h", rsp_data[63:0], pat[63:0]);
    end
    chk("r1_err", 64'(err_sticky), 64'(0));
    tick;
    chk("r1_rsp_drop", 64'(rsp_valid), 64'(0));
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0007;
    tick;
    c0_rx_valid = 1'b0;
    chk("bad_rspv",  64'(rsp_valid), 64'(0));
    chk("bad_err",   64'(err_sticky), 64'(1));
    chk("bad_total", 64'(outstanding_total), 64'(1));
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0203;
    tick;
    c0_rx_valid = 1'b0;
    chk("r3_rspv", 64'(rsp_valid), 64'(4'b1000));
    tick;
    chk("r3_total", 64'(outstanding_total), 64'(0));

    // quiesce with three reads in flight
    req_valid = 4'b0111;
    #1 chk("q_ready_a", 64'(req_ready), 64'(4'b0100));
    tick;
    #1 chk("q_ready_b", 64'(req_ready), 64'(4'b0001));
    tick;
    #1 chk("q_ready_c", 64'(req_ready), 64'(4'b0010));
    tick;
    quiesce_req = 1'b1;
    #1 chk("q_block",  64'(req_ready), 64'(0));
    chk("q_total3", 64'(outstanding_total), 64'(3));
    tick;
    chk("q_txv", 64'(c0_tx_valid), 64'(0));
    chk("q_ack_early", 64'(quiesce_ack), 64'(0));
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0002;
    tick;
    chk("q_ack_d1", 64'(quiesce_ack), 64'(0));
    c0_rx_mdata = 16'h0000;
    tick;
    chk("q_ack_d2", 64'(quiesce_ack), 64'(0));
    c0_rx_mdata = 16'h0001;
    tick;
    chk("q_ack_d3", 64'(quiesce_ack), 64'(0));
    chk("q_ready_drain", 64'(req_ready), 64'(0));
    c0_rx_valid = 1'b0;
    tick;
    chk("q_ack", 64'(quiesce_ack), 64'(1));
    chk("q_total0", 64'(outstanding_total), 64'(0));
    tick;
    chk("q_ack_hold", 64'(quiesce_ack), 64'(1));
    quiesce_req = 1'b0;
    #1 chk("q_ready_still", 64'(req_ready), 64'(0));
    tick;
    chk("q_ack_drop", 64'(quiesce_ack), 64'(0));
    chk("q_resume",   64'(req_ready), 64'(4'b0100));
    tick;
    chk("q_resume_txv", 64'(c0_tx_valid), 64'(1));

    // asynchronous reset mid-burst
    reset_n = 1'b0;
    #1;
    chk("ar_ready", 64'(req_ready), 64'(0));
    chk("ar_txv",   64'(c0_tx_valid), 64'(0));
    chk("ar_total", 64'(outstanding_total), 64'(0));
    chk("ar_err",   64'(err_sticky), 64'(0));
    chk("ar_rspv",  64'(rsp_valid), 64'(0));
    req_valid = '0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    c0_rx_valid = 1'b1;
    c0_rx_mdata = 16'h0001;
    tick;
    c0_rx_valid = 1'b0;
    chk("late_rspv", 64'(rsp_valid), 64'(0));
    chk("late_err",  64'(err_sticky), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
